// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
package cla_nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: every carry is built directly
// from generate/propagate terms and cin, with no ripple between bits.
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic       w_c4;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c1 = w_g[0] | (w_p[0] & i_cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ {w_c3, w_c2, w_c1, i_cin};
    assign o_cout = w_c4;

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock,
// least significant nibble first; approx mode drops inter-nibble carries.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// RUN   | one nibble per edge through the shared slice, idx 0..NIB-1
// DONE  | out_valid high, sum/cout held until out_ready
module cla_nibble_serial_adder
    import cla_nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = nib_count(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_approx;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_cin;
    logic [3:0]       w_s_nib;
    logic             w_slice_cout;

    assign w_a_nib = r_a[r_idx*NIB_W +: NIB_W];
    assign w_b_nib = r_b[r_idx*NIB_W +: NIB_W];
    assign w_cin   = r_approx ? 1'b0 : r_carry;

    cla4_slice u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (w_cin),
        .o_s    (w_s_nib),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_approx    <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_approx   <= approx;
                        r_carry    <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*NIB_W +: NIB_W] <= w_s_nib;
                    r_carry <= r_approx ? 1'b0 : w_slice_cout;
                    // idx returns to zero here so it never exceeds NIB-1
                    if (r_idx == IDX_LAST) begin
                        r_idx       <= '0;
                        r_cout      <= r_approx ? 1'b0 : w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
